// File: rtl/dino_pkg.sv
// Shared definitions for the dino motion controller, renderer and collision logic.
// Default physics constants live here so every consumer agrees on jump height.
package dino_pkg;
   localparam int YPOS_W       = 6;
   localparam int CNT_W        = 4;
   localparam int DEF_JUMP_VEL = 7;
   localparam int DEF_GRAVITY  = 1;
   localparam int DEF_COOLDOWN = 2;

   typedef enum logic [1:0] {
      ST_GROUND   = 2'd0,
      ST_AIR      = 2'd1,
      ST_COOLDOWN = 2'd2
   } dino_state_e;
endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Control/status bundle between game logic (master) and the dino jump controller (slave).
interface dino_jump_ctrl_if;
   logic                               i_frame_tick;
   logic                               i_jump;
   logic                               i_halt;
   logic                               i_restart;
   logic signed [dino_pkg::YPOS_W-1:0] o_ypos;
   logic                               o_airborne;
   logic                               o_jump_start;
   logic [1:0]                         o_state;

   modport master (
      output i_frame_tick, i_jump, i_halt, i_restart,
      input  o_ypos, o_airborne, o_jump_start, o_state
   );

   modport slave (
      input  i_frame_tick, i_jump, i_halt, i_restart,
      output o_ypos, o_airborne, o_jump_start, o_state
   );
endinterface

// File: rtl/dino_sync2.sv
// Generic 2-flop synchronizer with async reset and a synchronous clear.
module dino_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else if (clr) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/dino_jump_ctrl.sv
// Per-frame vertical motion controller for the dino sprite: takeoff, integer gravity, landing cooldown.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_GROUND   | on the ground, takeoff allowed when button held and armed
//   ST_AIR      | airborne, position integrates velocity each frame
//   ST_COOLDOWN | landed, counter runs down before the next takeoff
module dino_jump_ctrl
   import dino_pkg::*;
#(
   parameter int JUMP_VEL = DEF_JUMP_VEL,
   parameter int GRAVITY  = DEF_GRAVITY,
   parameter int COOLDOWN = DEF_COOLDOWN
) (
   input logic             clk,
   input logic             rst,
   dino_jump_ctrl_if.slave bus
);
   localparam logic signed [YPOS_W-1:0] VEL_TAKEOFF = YPOS_W'(-JUMP_VEL);
   localparam logic signed [YPOS_W-1:0] VEL_GRAV    = YPOS_W'(GRAVITY);
   localparam logic [CNT_W-1:0]         CNT_LOAD    = CNT_W'(COOLDOWN);
   localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);

   dino_state_e               state, state_nxt;
   logic signed [YPOS_W-1:0]  ypos, ypos_nxt;
   logic signed [YPOS_W-1:0]  vel, vel_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic                      armed, armed_nxt;
   logic                      jump_s;
   logic                      jump_start;
   logic                      tick_ok;
   logic                      vel_pos;
   logic signed [YPOS_W:0]    sum;

   dino_sync2 #(.W(1)) u_sync_jump (
      .clk (clk),
      .rst (rst),
      .clr (bus.i_restart),
      .d   (bus.i_jump),
      .q   (jump_s)
   );

   assign tick_ok = bus.i_frame_tick & ~bus.i_halt & ~bus.i_restart;
   // Sum one bit wider than ypos so a landing crossing zero is detected by its sign.
   assign sum     = {ypos[YPOS_W-1], ypos} + {vel[YPOS_W-1], vel};
   assign vel_pos = ~vel[YPOS_W-1] & (vel != '0);

   always_comb begin
      state_nxt  = state;
      ypos_nxt   = ypos;
      vel_nxt    = vel;
      cnt_nxt    = cnt;
      armed_nxt  = armed | ~jump_s;
      jump_start = 1'b0;
      if (bus.i_restart) begin
         state_nxt = ST_GROUND;
         ypos_nxt  = '0;
         vel_nxt   = '0;
         cnt_nxt   = '0;
         armed_nxt = 1'b1;
      end else if (tick_ok) begin
         case (state)
            ST_GROUND: begin
               if (jump_s && armed) begin
                  state_nxt  = ST_AIR;
                  vel_nxt    = VEL_TAKEOFF;
                  armed_nxt  = 1'b0;
                  jump_start = 1'b1;
               end
            end
            ST_AIR: begin
               if (vel_pos && !sum[YPOS_W]) begin
                  ypos_nxt = '0;
                  vel_nxt  = '0;
                  if (COOLDOWN == 0) begin
                     state_nxt = ST_GROUND;
                  end else begin
                     state_nxt = ST_COOLDOWN;
                     cnt_nxt   = CNT_LOAD;
                  end
               end else begin
                  ypos_nxt = sum[YPOS_W-1:0];
                  vel_nxt  = vel + VEL_GRAV;
               end
            end
            ST_COOLDOWN: begin
               if (cnt <= CNT_ONE) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_GROUND;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
            default: state_nxt = ST_GROUND;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_GROUND;
         ypos  <= '0;
         vel   <= '0;
         cnt   <= '0;
         armed <= 1'b1;
      end else begin
         state <= state_nxt;
         ypos  <= ypos_nxt;
         vel   <= vel_nxt;
         cnt   <= cnt_nxt;
         armed <= armed_nxt;
      end
   end

   assign bus.o_ypos       = ypos;
   assign bus.o_airborne   = (state == ST_AIR);
   assign bus.o_jump_start = jump_start;
   assign bus.o_state      = state;
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Scoreboard bench for dino_jump_ctrl: each frame tick queues its expected response,
// a negedge monitor checks the takeoff pulse during the tick and position/state after it.
module tb_dino_jump_ctrl;
   import dino_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dino_jump_ctrl_if bus();

   dino_jump_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit js;
      int y;
      int st;
   } exp_t;

   exp_t q[$];
   exp_t pend;
   bit   pend_v = 1'b0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   int   air_tbl[14] = '{-7, -13, -18, -22, -25, -27, -28, -28, -27, -25, -22, -18, -13, -7};

   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      int y;
      y = $signed(bus.o_ypos);
      if (pend_v) begin
         chk("ypos", y, pend.y);
         chk("state", int'(bus.o_state), pend.st);
         chk("airborne", int'(bus.o_airborne), (pend.st == int'(ST_AIR)) ? 1 : 0);
         pend_v = 1'b0;
      end
      if (bus.i_frame_tick) begin
         if (q.size() == 0) begin
            chk("tick_without_expectation", 1, 0);
         end else begin
            pend = q.pop_front();
            chk("jump_start", int'(bus.o_jump_start), int'(pend.js));
            pend_v = 1'b1;
         end
      end
   end

   // Called and returns at posedge+1; tick is high for one full cycle.
   task automatic tick(input bit js, input int y, input int st);
      exp_t e;
      e.js = js; e.y = y; e.st = st;
      q.push_back(e);
      bus.i_frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.i_frame_tick = 1'b0;
      bus.i_restart    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.i_frame_tick = 1'b0;
      bus.i_jump       = 1'b0;
      bus.i_halt       = 1'b0;
      bus.i_restart    = 1'b0;
      rst              = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ypos", int'($signed(bus.o_ypos)), 0);
      chk("rst_state", int'(bus.o_state), int'(ST_GROUND));
      chk("rst_airborne", int'(bus.o_airborne), 0);
      chk("rst_jump_start", int'(bus.o_jump_start), 0);
      wait_cyc(1);

      // basic jump, button held throughout
      bus.i_jump = 1'b1;
      wait_cyc(3);
      tick(1, 0, int'(ST_AIR));
      for (int i = 0; i < 14; i++) tick(0, air_tbl[i], int'(ST_AIR));
      tick(0, 0, int'(ST_COOLDOWN));
      // held through cooldown and beyond: no retrigger
      tick(0, 0, int'(ST_COOLDOWN));
      tick(0, 0, int'(ST_GROUND));
      for (int i = 0; i < 3; i++) tick(0, 0, int'(ST_GROUND));

      // release then press re-arms
      bus.i_jump = 1'b0;
      wait_cyc(3);
      bus.i_jump = 1'b1;
      wait_cyc(3);
      tick(1, 0, int'(ST_AIR));
      bus.i_jump = 1'b0;
      for (int i = 0; i < 5; i++) tick(0, air_tbl[i], int'(ST_AIR));
      // halt at -25
      bus.i_halt = 1'b1;
      for (int i = 0; i < 10; i++) tick(0, -25, int'(ST_AIR));
      bus.i_halt = 1'b0;
      for (int i = 5; i < 14; i++) tick(0, air_tbl[i], int'(ST_AIR));
      // press before landing: ignored in AIR and COOLDOWN, accepted once back on ground
      bus.i_jump = 1'b1;
      wait_cyc(3);
      tick(0, 0, int'(ST_COOLDOWN));
      tick(0, 0, int'(ST_COOLDOWN));
      tick(0, 0, int'(ST_GROUND));
      tick(1, 0, int'(ST_AIR));

      // restart coincident with a tick at -18
      for (int i = 0; i < 3; i++) tick(0, air_tbl[i], int'(ST_AIR));
      bus.i_restart = 1'b1;
      tick(0, 0, int'(ST_GROUND));
      wait_cyc(1);
      tick(1, 0, int'(ST_AIR));

      // async reset mid-jump at -28
      for (int i = 0; i < 7; i++) tick(0, air_tbl[i], int'(ST_AIR));
      #3 rst = 1'b1;
      #1;
      chk("arst_ypos", int'($signed(bus.o_ypos)), 0);
      chk("arst_state", int'(bus.o_state), int'(ST_GROUND));
      chk("arst_airborne", int'(bus.o_airborne), 0);
      chk("arst_jump_start", int'(bus.o_jump_start), 0);
      wait_cyc(1);
      rst = 1'b0;
      wait_cyc(3);
      tick(1, 0, int'(ST_AIR));

      // restart without a tick
      bus.i_restart = 1'b1;
      wait_cyc(1);
      bus.i_restart = 1'b0;
      bus.i_jump    = 1'b0;
      @(negedge clk);
      chk("restart_state", int'(bus.o_state), int'(ST_GROUND));
      chk("restart_ypos", int'($signed(bus.o_ypos)), 0);
      wait_cyc(4);

      // synchronizer latency: one-cycle pulse just before a tick is too late
      bus.i_jump = 1'b1;
      wait_cyc(1);
      bus.i_jump = 1'b0;
      tick(0, 0, int'(ST_GROUND));
      wait_cyc(3);
      bus.i_jump = 1'b1;
      wait_cyc(3);
      tick(1, 0, int'(ST_AIR));

      wait_cyc(4);
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dino_jump_ctrl.md
Name: dino_jump_ctrl

Overview:
Player-motion controller that sequences the dino sprite's vertical position once per video frame.
- Samples the jump button and runs a takeoff / airborne / cooldown state machine with integer gravity.
- Drives the 6-bit signed vertical offset consumed by the dino renderer (negative = sprite drawn higher).
- Sits between the input-conditioning logic and the dino renderer; the game-state logic freezes it (halt) and resets it (restart).

Parameters:
JUMP_VEL, 7, magnitude of initial upward velocity in pixels/frame; must satisfy JUMP_VEL*(JUMP_VEL+1)/2 <= 32.
GRAVITY, 1, velocity increment per frame tick.
COOLDOWN, 2, frame ticks on ground after landing before a new takeoff is accepted.

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous, active-high reset
i_frame_tick  in  1  single-cycle pulse once per frame (start of vblank)
i_jump  in  1  raw jump button, asynchronous to clk, active-high
i_halt  in  1  level; freezes all motion state (game over / pause)
i_restart  in  1  single-cycle pulse; synchronous return to reset state
o_ypos  out  6  signed two's-complement vertical offset for the renderer; 0 = on ground
o_airborne  out  1  high while state is AIR
o_jump_start  out  1  single-cycle pulse on the takeoff cycle (sound / score hooks)
o_state  out  2  current FSM state encoding (debug)

Behaviour:
- Reset (async rst, or i_restart in a synchronous cycle) forces the following:
  - registers: o_ypos=0, vel=0, state=GROUND, cooldown counter=0, armed=1, synchronizer flops=0;
  - outputs: o_airborne=0, o_jump_start=0, o_state=GROUND.
- i_jump passes through a 2-flop synchronizer; jump_s is the synchronized value, 2 cycles of latency.
- armed:
  - cleared on takeoff;
  - set on any clk cycle where jump_s=0, even during halt;
  - requires a release between jumps, so holding the button never auto-retriggers.
- All motion updates occur only on cycles with i_frame_tick=1 and i_halt=0.
- Outputs are registered: the new o_ypos is visible the cycle after the tick.
- States: GROUND=0, AIR=1, COOLDOWN=2; encoding 3 is unused and recovers to GROUND.
- GROUND, on a qualifying tick with jump_s=1 and armed=1 (takeoff):
  - state<=AIR, vel<=-JUMP_VEL, o_ypos unchanged (0);
  - o_jump_start=1 for exactly that one cycle; armed<=0.
- AIR, on a qualifying tick, with s = o_ypos + vel computed at 7 bits signed:
  - if vel>0 and s>=0 (landing): o_ypos<=0, vel<=0, state<=COOLDOWN, counter<=COOLDOWN.
    - If COOLDOWN=0, go directly to GROUND.
  - otherwise: o_ypos<=s[5:0], vel<=vel+GRAVITY.
- COOLDOWN: each qualifying tick decrements the counter; when it reaches 0, state<=GROUND.
  - Jump presses are ignored during COOLDOWN; armed still tracks releases.
- vel is a 6-bit signed register; parameter limits guarantee no overflow of o_ypos or vel.
- i_halt=1: all state, o_ypos, vel and counter hold; ticks are ignored; o_jump_start=0.
- Simultaneous events, priority: rst > i_restart > i_halt > tick.
  - A restart during halt resets normally.
  - A tick coinciding with restart is discarded.
- o_jump_start never asserts on a cycle without a qualifying tick.

Decomposition:
- Shared package dino_pkg holds:
  - state typedef: GROUND, AIR, COOLDOWN;
  - YPOS_W=6;
  - default JUMP_VEL, GRAVITY, COOLDOWN constants, shared with the renderer and the obstacle collision logic.
- One sub-module, dino_sync2: generic 2-flop synchronizer with async reset; reused for other button inputs.
- FSM and physics datapath stay in dino_jump_ctrl.

Test Plan:
- Basic jump:
  - Stimulus: rst, then hold i_jump, issue ticks.
  - Required response:
    - takeoff tick gives o_jump_start=1 and o_ypos=0;
    - the next 14 ticks give o_ypos = -7,-13,-18,-22,-25,-27,-28,-28,-27,-25,-22,-18,-13,-7;
    - the 15th tick gives o_ypos=0 and state COOLDOWN.
- Cooldown and re-arm:
  - Stimulus: keep i_jump held through landing plus 5 ticks.
  - Required response: no second takeoff while held.
  - Then release for 3 cycles and press again: takeoff on the first tick after COOLDOWN expires (2 ticks after landing) and jump_s=1.
- Halt mid-air:
  - Stimulus: i_halt=1 when o_ypos=-25 (vel=-2), apply 10 ticks, then deassert i_halt.
  - Required response: o_ypos stays -25 during halt; the next tick gives -27.
- Restart priority:
  - Stimulus: i_restart coincident with a tick while in AIR at o_ypos=-18.
  - Required response: next cycle o_ypos=0, state GROUND, o_airborne=0, no o_jump_start.
- Async reset mid-jump:
  - Stimulus: assert rst between clock edges at o_ypos=-28.
  - Required response: o_ypos=0 immediately; all outputs at reset values; armed=1.
- Synchronizer latency:
  - Stimulus: pulse i_jump 1 cycle before a tick.
  - Required response: no takeoff on that tick.
  - Stimulus: pulse held for 3+ cycles before a tick.
  - Required response: takeoff on that tick.
